// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback (A) and the
// long-latency unit (B), with B starvation protection and a pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_a_valid,
  input  logic [4:0]  i_a_addr,
  input  logic [31:0] i_a_data,
  output logic        o_a_stall,
  input  logic        i_b_valid,
  input  logic [4:0]  i_b_addr,
  input  logic [31:0] i_b_data,
  output logic        o_b_ready,
  input  logic        i_issue_valid,
  input  logic [4:0]  i_issue_addr,
  output logic [31:0] o_busy_mask,
  output logic        o_rd_wen,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data
);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved, grant_a, grant_b;
  logic [31:0]      set_vec, clr_vec;

  assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Everything is gated by reset so an in-flight B request is dropped, not accepted.
  always_comb begin
    o_a_stall = !i_rst & starved & i_a_valid & i_b_valid;
    grant_a   = !i_rst & i_a_valid & !o_a_stall;
    grant_b   = !i_rst & i_b_valid & !grant_a;
    o_b_ready = grant_b;
    o_rd_addr = 5'd0;
    o_rd_data = 32'd0;
    if (grant_a) begin
      o_rd_addr = i_a_addr;
      o_rd_data = i_a_data;
    end else if (grant_b) begin
      o_rd_addr = i_b_addr;
      o_rd_data = i_b_data;
    end
    o_rd_wen = (grant_a | grant_b) & (o_rd_addr != 5'd0);
  end

  always_comb begin
    set_vec = 32'd0;
    clr_vec = 32'd0;
    for (int n = 1; n < 32; n++) begin
      set_vec[n] = i_issue_valid & (i_issue_addr == 5'(n));
      clr_vec[n] = grant_b & (i_b_addr == 5'(n));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      starve_cnt  <= '0;
      o_busy_mask <= 32'd0;
    end else begin
      if (i_b_valid & !grant_b) begin
        if (!starved) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
      // Set after clear: a fresh issue overrides a same-cycle retirement.
      o_busy_mask <= ((o_busy_mask & ~clr_vec) | set_vec) & 32'hFFFF_FFFE;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table, reset corner
// sequence, and randomized traffic against a behavioural model.
module tb_regfile_wb_arbiter;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, issue_valid;
  logic [4:0]  a_addr, b_addr, issue_addr;
  logic [31:0] a_data, b_data;
  logic        a_stall, b_ready, rd_wen;
  logic [31:0] busy_mask, rd_data;
  logic [4:0]  rd_addr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.STARVE_LIMIT(LIM), .CNT_W(3)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_a_valid(a_valid), .i_a_addr(a_addr), .i_a_data(a_data), .o_a_stall(a_stall),
    .i_b_valid(b_valid), .i_b_addr(b_addr), .i_b_data(b_data), .o_b_ready(b_ready),
    .i_issue_valid(issue_valid), .i_issue_addr(issue_addr), .o_busy_mask(busy_mask),
    .o_rd_wen(rd_wen), .o_rd_addr(rd_addr), .o_rd_data(rd_data)
  );

  typedef struct {
    logic        av; logic [4:0] aa; logic [31:0] ad;
    logic        bv; logic [4:0] ba; logic [31:0] bd;
    logic        iv; logic [4:0] ia;
    logic        stall, brdy, wen; logic [4:0] waddr; logic [31:0] wdata;
    logic [31:0] mask;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(logic av, logic [4:0] aa, logic [31:0] ad,
                              logic bv, logic [4:0] ba, logic [31:0] bd,
                              logic iv, logic [4:0] ia,
                              logic st, logic br, logic we, logic [4:0] wa,
                              logic [31:0] wd, logic [31:0] mk_mask);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
    v.iv = iv; v.ia = ia; v.stall = st; v.brdy = br; v.wen = we;
    v.waddr = wa; v.wdata = wd; v.mask = mk_mask;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic av, logic [4:0] aa, logic [31:0] ad,
                       logic bv, logic [4:0] ba, logic [31:0] bd,
                       logic iv, logic [4:0] ia);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    issue_valid = iv; issue_addr = ia;
  endtask

  task automatic chk_out(string tag, logic st, logic br, logic we,
                         logic [4:0] wa, logic [31:0] wd);
    chk({tag, ".stall"}, {31'd0, a_stall}, {31'd0, st});
    chk({tag, ".b_ready"}, {31'd0, b_ready}, {31'd0, br});
    chk({tag, ".wen"}, {31'd0, rd_wen}, {31'd0, we});
    chk({tag, ".addr"}, {27'd0, rd_addr}, {27'd0, wa});
    chk({tag, ".data"}, rd_data, wd);
  endtask

  // behavioural model state
  int          m_wait;
  logic [31:0] m_busy;

  initial begin
    // A x3 / B x9 contention pattern, then scoreboard and x0 corners.
    tbl[0]  = mk(1,5,32'h11, 0,0,0,        0,0, 0,0,1,5,32'h11, 32'h0);
    tbl[1]  = mk(1,3,32'h33, 1,9,32'h99,   0,0, 0,0,1,3,32'h33, 32'h0);
    tbl[2]  = mk(1,3,32'h33, 1,9,32'h99,   0,0, 0,0,1,3,32'h33, 32'h0);
    tbl[3]  = mk(1,3,32'h33, 1,9,32'h99,   0,0, 0,0,1,3,32'h33, 32'h0);
    tbl[4]  = mk(1,3,32'h33, 1,9,32'h99,   0,0, 0,0,1,3,32'h33, 32'h0);
    tbl[5]  = mk(1,3,32'h33, 1,9,32'h99,   0,0, 1,1,1,9,32'h99, 32'h0);
    tbl[6]  = mk(1,3,32'h33, 1,9,32'h99,   0,0, 0,0,1,3,32'h33, 32'h0);
    tbl[7]  = mk(0,0,0,      0,0,0,        1,7, 0,0,0,0,32'h0,  32'h80);
    tbl[8]  = mk(0,0,0,      1,7,32'h77,   0,0, 0,1,1,7,32'h77, 32'h0);
    tbl[9]  = mk(0,0,0,      0,0,0,        1,7, 0,0,0,0,32'h0,  32'h80);
    tbl[10] = mk(0,0,0,      1,7,32'h70,   1,7, 0,1,1,7,32'h70, 32'h80);
    tbl[11] = mk(1,0,32'hAA, 0,0,0,        0,0, 0,0,0,0,32'hAA, 32'h80);
    tbl[12] = mk(0,0,0,      0,0,0,        1,0, 0,0,0,0,32'h0,  32'h80);
    tbl[13] = mk(0,0,0,      1,0,32'hBB,   1,2, 0,1,0,0,32'hBB, 32'h84);
    tbl[14] = mk(0,0,0,      0,0,0,        0,0, 0,0,0,0,32'h0,  32'h84);

    // Reset with requests pending: outputs must stay quiet.
    rst = 1'b1;
    drive(1,5,32'h55, 1,6,32'h66, 1,4);
    @(posedge clk); #1;
    @(negedge clk);
    chk_out("rst", 0,0,0,0,32'h0);
    @(posedge clk); #1;
    chk("rst.mask", busy_mask, 32'h0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].bv, tbl[i].ba, tbl[i].bd,
            tbl[i].iv, tbl[i].ia);
      @(negedge clk);
      chk_out($sformatf("vec%0d", i), tbl[i].stall, tbl[i].brdy, tbl[i].wen,
              tbl[i].waddr, tbl[i].wdata);
      @(posedge clk); #1;
      chk($sformatf("vec%0d.mask", i), busy_mask, tbl[i].mask);
    end

    // Mid-run reset: build up 3 cycles of B waiting with mask 0x84, then pulse reset.
    for (int k = 0; k < 3; k++) begin
      drive(1,3,32'h33, 1,9,32'h99, 0,0);
      @(negedge clk);
      chk_out($sformatf("pre%0d", k), 0,0,1,3,32'h33);
      @(posedge clk); #1;
    end
    chk("pre.mask", busy_mask, 32'h84);
    rst = 1'b1;
    drive(1,3,32'h33, 1,9,32'h99, 1,4);
    @(negedge clk);
    chk_out("midrst", 0,0,0,0,32'h0);
    @(posedge clk); #1;
    chk("midrst.mask", busy_mask, 32'h0);
    rst = 1'b0;
    // Counter must restart from 0: four A wins before B is forced through.
    for (int k = 0; k < 5; k++) begin
      drive(1,3,32'h33, 1,9,32'h99, 0,0);
      @(negedge clk);
      if (k < 4) chk_out($sformatf("post%0d", k), 0,0,1,3,32'h33);
      else       chk_out("post4", 1,1,1,9,32'h99);
      @(posedge clk); #1;
    end

    // Randomized traffic vs. model.
    rst = 1'b1;
    drive(0,0,0, 0,0,0, 0,0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_wait = 0;
    m_busy = 32'h0;
    for (int c = 0; c < 400; c++) begin
      logic r, av, bv, iv, starved, st, ga, gb, we;
      logic [4:0] aa, ba, ia, wa;
      logic [31:0] ad, bd, wd;
      r  = ($urandom_range(0, 39) == 0);
      av = ($urandom_range(0, 9) < 7);
      bv = ($urandom_range(0, 9) < 6);
      iv = ($urandom_range(0, 9) < 4);
      aa = 5'($urandom_range(0, 7));
      ba = 5'($urandom_range(0, 7));
      ia = 5'($urandom_range(0, 7));
      ad = $urandom;
      bd = $urandom;
      rst = r;
      drive(av,aa,ad, bv,ba,bd, iv,ia);
      starved = (m_wait == LIM);
      st = !r && starved && av && bv;
      ga = !r && av && !st;
      gb = !r && bv && !ga;
      wa = ga ? aa : (gb ? ba : 5'd0);
      wd = ga ? ad : (gb ? bd : 32'd0);
      we = (ga || gb) && (wa != 5'd0);
      @(negedge clk);
      chk_out($sformatf("rnd%0d", c), st, gb, we, wa, wd);
      @(posedge clk); #1;
      if (r) begin
        m_wait = 0;
        m_busy = 32'h0;
      end else begin
        if (bv && !gb) m_wait = (m_wait < LIM) ? m_wait + 1 : LIM;
        else           m_wait = 0;
        if (gb) m_busy[ba] = 1'b0;
        if (iv && ia != 5'd0) m_busy[ia] = 1'b1;
      end
      chk($sformatf("rnd%0d.mask", c), busy_mask, m_busy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
